// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file write-back path.
//   XLEN   : data width of one register
//   NREG   : number of architectural registers
//   REG_AW : register address width
//   reg_addr_t : register index
//   wb_req_t   : one write-back request (destination + data)
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr_i and wraps, so the first requester at or after ptr_i wins.
// Ports:
//   req_i       in  N   request vector
//   ptr_i       in  PW  index where the search starts
//   gnt_o       out N   one-hot grant, or all zero when nothing is requested
//   gnt_idx_o   out PW  index of the granted requester (0 when gnt_valid_o=0)
//   gnt_valid_o out 1   some requester is granted
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  // (base + off) mod N, with off < N, so a single conditional subtract is enough.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(N)) s = s - 32'(N);
    return s[PW-1:0];
  endfunction

  logic [PW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    w_cand      = '0;
    w_found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = wrap_add(ptr_i, 32'(k));
      if (!w_found && req_i[w_cand]) begin
        gnt_o[w_cand] = 1'b1;
        gnt_idx_o     = w_cand;
        gnt_valid_o   = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the integer register file.
// Arbitrates NUM_REQ write-back sources onto the single regfile write port and keeps a
// busy scoreboard of destinations that have been issued but not yet written back.
// Ports:
//   clk_i, rst_ni             clock (rising edge), asynchronous active-low reset
//   wb_valid_i/addr_i/data_i  per-requester write request (packed, requester 0 in low bits)
//   wb_ready_o                per-requester grant, combinational
//   iss_valid_i, iss_rd_i     issued instruction that will write iss_rd_i
//   rs1/rs2_addr_i            decode source queries
//   rs1/rs2_busy_o            registered busy bit of the queried register
//   rd_addr_o/data_o/wren_o   registered regfile write port
//
// Handshake: a write transfers in a cycle where wb_valid_i[i] & wb_ready_o[i]. A requester
// keeps addr/data stable and valid high until that happens. At most one ready per cycle;
// ready is never given while reset is asserted.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       wb_valid_i,
  input  logic [NUM_REQ*REG_AW-1:0] wb_addr_i,
  input  logic [NUM_REQ*XLEN-1:0]  wb_data_i,
  output logic [NUM_REQ-1:0]       wb_ready_o,
  input  logic                     iss_valid_i,
  input  logic [REG_AW-1:0]        iss_rd_i,
  input  logic [REG_AW-1:0]        rs1_addr_i,
  input  logic [REG_AW-1:0]        rs2_addr_i,
  output logic                     rs1_busy_o,
  output logic                     rs2_busy_o,
  output logic [REG_AW-1:0]        rd_addr_o,
  output logic [XLEN-1:0]          rd_data_o,
  output logic                     rd_wren_o
);

  wb_req_t             w_req [NUM_REQ];
  wb_req_t             w_sel;
  logic [NUM_REQ-1:0]  w_req_vld;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic                w_gnt_valid;
  logic                w_sel_nz;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic [NREG-1:0]     w_busy_nxt;

  logic [PTR_W-1:0]    r_rr_ptr;
  logic [NREG-1:0]     r_busy;
  logic [REG_AW-1:0]   r_rd_addr;
  logic [XLEN-1:0]     r_rd_data;
  logic                r_rd_wren;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req[g].addr = wb_addr_i[g*REG_AW +: REG_AW];
    assign w_req[g].data = wb_data_i[g*XLEN +: XLEN];
  end

  // Masking requests with rst_ni keeps ready low for the whole reset window.
  assign w_req_vld = wb_valid_i & {NUM_REQ{rst_ni}};

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i       (w_req_vld),
    .ptr_i       (r_rr_ptr),
    .gnt_o       (w_gnt),
    .gnt_idx_o   (w_gnt_idx),
    .gnt_valid_o (w_gnt_valid)
  );

  assign wb_ready_o = w_gnt;
  assign w_sel      = w_req[w_gnt_idx];
  assign w_sel_nz   = (w_sel.addr != '0);
  assign w_ptr_nxt  = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

  // Clear first, then set: a same-cycle issue to the register being written back wins,
  // since that newer producer is still outstanding. Entry 0 is never busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_gnt_valid && w_sel_nz) w_busy_nxt[w_sel.addr] = 1'b0;
    if (iss_valid_i && (iss_rd_i != '0)) w_busy_nxt[iss_rd_i] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr  <= '0;
      r_busy    <= '0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_rd_wren <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_gnt_valid) begin
        r_rd_addr <= w_sel.addr;
        r_rd_data <= w_sel.data;
        // The regfile does not protect entry 0, so writes to x0 are swallowed here.
        r_rd_wren <= w_sel_nz;
        r_rr_ptr  <= w_ptr_nxt;
      end else begin
        r_rd_wren <= 1'b0;
      end
    end
  end

  // No bypass of a same-cycle clear: decode sees the write-back one cycle later.
  assign rs1_busy_o = r_busy[rs1_addr_i];
  assign rs2_busy_o = r_busy[rs2_addr_i];

  assign rd_addr_o = r_rd_addr;
  assign rd_data_o = r_rd_data;
  assign rd_wren_o = r_rd_wren;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  localparam int NR = 2;
  localparam int EW = 1 + REG_AW + XLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]        wb_valid;
  logic [NR*REG_AW-1:0] wb_addr;
  logic [NR*XLEN-1:0]   wb_data;
  logic [NR-1:0]        wb_ready;
  logic                 iss_valid;
  logic [REG_AW-1:0]    iss_rd;
  logic [REG_AW-1:0]    rs1, rs2;
  logic                 rs1_busy, rs2_busy;
  logic [REG_AW-1:0]    rd_addr;
  logic [XLEN-1:0]      rd_data;
  logic                 rd_wren;

  regfile_wb_ctrl #(.NUM_REQ(NR)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wb_valid_i  (wb_valid),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .wb_ready_o  (wb_ready),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .rs1_addr_i  (rs1),
    .rs2_addr_i  (rs2),
    .rs1_busy_o  (rs1_busy),
    .rs2_busy_o  (rs2_busy),
    .rd_addr_o   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_wren_o   (rd_wren)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model: round-robin pointer, busy set of registers, last grant vector.
  int            m_ptr = 0;
  bit [NREG-1:0] m_busy = '0;
  logic [NR-1:0] last_gnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: evaluates mid-cycle with stable inputs, predicts the grant and the busy bits,
  // pushes the expected write port value for the next cycle, then advances its own state.
  always @(negedge clk) begin : model
    int g;
    int idx;
    logic [NR-1:0]     eg;
    logic [REG_AW-1:0] a;
    logic [XLEN-1:0]   d;
    if (rst_n) begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (g < 0 && wb_valid[idx]) g = idx;
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      chk("ready", wb_ready, eg);
      chk("rs1_busy", rs1_busy, m_busy[rs1]);
      chk("rs2_busy", rs2_busy, m_busy[rs2]);
      if (g >= 0) begin
        a = wb_addr[g*REG_AW +: REG_AW];
        d = wb_data[g*XLEN +: XLEN];
        exp_q.push_back({(a != 0), a, d});
        m_ptr = (g + 1) % NR;
        if (a != 0) m_busy[a] = 1'b0;
      end else begin
        exp_q.push_back('0);
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      last_gnt = eg;
    end else begin
      last_gnt = '0;
    end
  end

  // Monitor: compares the registered write port against the queued expectation.
  always @(posedge clk) begin : monitor
    logic [EW-1:0] e;
    #2;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_wren", rd_wren, e[EW-1]);
      if (e[EW-1]) begin
        chk("rd_addr", rd_addr, e[XLEN +: REG_AW]);
        chk("rd_data", rd_data, e[XLEN-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (wb_valid[i] && last_gnt[i]) wb_valid[i] = 1'b0;
    iss_valid = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
    wb_valid[i]                = 1'b1;
    wb_addr[i*REG_AW +: REG_AW] = a;
    wb_data[i*XLEN +: XLEN]     = d;
  endtask

  task automatic issue(input logic [REG_AW-1:0] a);
    iss_valid = 1'b1;
    iss_rd    = a;
  endtask

  task automatic rand_addr(output logic [REG_AW-1:0] a);
    a = ($urandom_range(0, 7) == 0) ? '0 : REG_AW'($urandom_range(1, NREG - 1));
  endtask

  task automatic random_cycles(input int n);
    logic [REG_AW-1:0] a;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (!wb_valid[i] && $urandom_range(0, 99) < 60) begin
          rand_addr(a);
          set_req(i, a, $urandom);
        end
      end
      if ($urandom_range(0, 2) == 0) issue(REG_AW'($urandom_range(0, NREG - 1)));
      rs1 = REG_AW'($urandom_range(0, NREG - 1));
      rs2 = REG_AW'($urandom_range(0, NREG - 1));
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 10 && wb_valid != '0; c++) tick();
    chk("drain_done", wb_valid, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    wb_valid  = '0;
    wb_addr   = '0;
    wb_data   = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    rs1       = 5'd7;
    rs2       = 5'd31;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_wren", rd_wren, 1'b0);
    chk("reset_addr", rd_addr, '0);
    chk("reset_data", rd_data, '0);
    chk("reset_rs1_busy", rs1_busy, 1'b0);
    wb_valid = 2'b11;
    #1;
    chk("reset_no_ready", wb_ready, 2'b00);
    wb_valid = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Contention from rr_ptr=0: grants alternate 0,1,0,1.
    tick();
    set_req(0, 5'd1, 32'hA000_0000);
    set_req(1, 5'd2, 32'hB000_0000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("contention_gnt", wb_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (c < 3) begin
        if (!wb_valid[0]) set_req(0, REG_AW'($urandom_range(1, 31)), $urandom);
        if (!wb_valid[1]) set_req(1, REG_AW'($urandom_range(1, 31)), $urandom);
      end
    end
    drain();

    // Single write with one-cycle latency.
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    tick();
    chk("single_wren", rd_wren, 1'b1);
    chk("single_addr", rd_addr, 5'd5);
    chk("single_data", rd_data, 32'hDEAD_BEEF);
    tick();
    chk("single_idle_wren", rd_wren, 1'b0);

    // Write to x0 is accepted but never reaches the regfile.
    set_req(1, 5'd0, 32'h0000_1234);
    @(negedge clk);
    #1;
    chk("x0_ready", wb_ready, 2'b10);
    tick();
    chk("x0_wren", rd_wren, 1'b0);
    rs1 = 5'd0;
    #1;
    chk("x0_busy", rs1_busy, 1'b0);

    // Scoreboard set / clear / same-cycle set wins.
    rs1 = 5'd7;
    issue(5'd7);
    tick();
    chk("sb_set7", rs1_busy, 1'b1);
    set_req(0, 5'd7, $urandom);
    tick();
    chk("sb_clr7", rs1_busy, 1'b0);
    issue(5'd7);
    set_req(0, 5'd7, $urandom);
    tick();
    chk("sb_setwins7", rs1_busy, 1'b1);
    set_req(0, 5'd7, $urandom);
    tick();
    chk("sb_clr7_again", rs1_busy, 1'b0);

    // Issue to x0 is ignored; set and clear of different registers both land.
    issue(5'd0);
    rs1 = 5'd0;
    tick();
    chk("sb_iss_x0", rs1_busy, 1'b0);
    issue(5'd3);
    rs2 = 5'd3;
    tick();
    chk("sb_set3", rs2_busy, 1'b1);
    issue(5'd9);
    set_req(1, 5'd3, $urandom);
    rs1 = 5'd9;
    tick();
    chk("sb_set9", rs1_busy, 1'b1);
    chk("sb_clr3", rs2_busy, 1'b0);

    // Randomized traffic.
    random_cycles(400);
    tick();
    drain();

    // Reset mid-run: busy = 0x0F00 and a write on the port, then asynchronous reset.
    for (int r = 1; r < NREG; r++) begin
      if (m_busy[r]) begin
        set_req(0, REG_AW'(r), $urandom);
        tick();
      end
    end
    tick();
    for (int r = 8; r < 12; r++) begin
      issue(REG_AW'(r));
      tick();
    end
    chk("pre_reset_busy_set", 32'(m_busy), 32'h0000_0F00);
    set_req(0, 5'd5, 32'hCAFE_F00D);
    tick();
    set_req(1, 5'd6, 32'h5555_AAAA);
    rs1 = 5'd8;
    rs2 = 5'd11;
    #1;
    chk("pre_reset_wren", rd_wren, 1'b1);
    chk("pre_reset_busy8", rs1_busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_wren", rd_wren, 1'b0);
    chk("async_addr", rd_addr, '0);
    chk("async_data", rd_data, '0);
    chk("async_ready", wb_ready, 2'b00);
    chk("async_busy8", rs1_busy, 1'b0);
    chk("async_busy11", rs2_busy, 1'b0);
    rs1 = 5'd9;
    rs2 = 5'd10;
    #1;
    chk("async_busy9", rs1_busy, 1'b0);
    chk("async_busy10", rs2_busy, 1'b0);
    wb_valid = '0;
    m_ptr    = 0;
    m_busy   = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // After reset the pointer is back at requester 0.
    tick();
    set_req(0, 5'd12, 32'h0BAD_F00D);
    set_req(1, 5'd13, 32'h0000_BEEF);
    @(negedge clk);
    #1;
    chk("post_reset_gnt", wb_ready, 2'b01);
    random_cycles(60);
    tick();
    drain();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
